// File: rtl/alu_pkg.sv
// Shared ALU definitions for the operand stage: opcode constants, the ID/EX
// pipeline register layout, and the bubble pattern loaded on a flush.
package alu_pkg;

    // Widths of the ID/EX register fields. The operand stage parameters
    // default to these values and must match them.
    localparam int PKG_DATA_WIDTH     = 32;
    localparam int PKG_OPCODE_LENGTH  = 4;
    localparam int PKG_REG_ADDR_WIDTH = 5;

    // ALU operation codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_XOR = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_EQ  = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_LUI = 4'b1010;
    localparam logic [3:0] ALU_SRL = 4'b1100;
    localparam logic [3:0] ALU_SLT = 4'b1110;

    // ID/EX pipeline register contents
    typedef struct packed {
        logic                          valid;
        logic                          reg_write;
        logic                          a_sel_pc;
        logic                          b_sel_imm;
        logic [PKG_OPCODE_LENGTH-1:0]  alu_op;
        logic [PKG_REG_ADDR_WIDTH-1:0] rs1;
        logic [PKG_REG_ADDR_WIDTH-1:0] rs2;
        logic [PKG_REG_ADDR_WIDTH-1:0] rd;
        logic [PKG_DATA_WIDTH-1:0]     rs1_data;
        logic [PKG_DATA_WIDTH-1:0]     rs2_data;
        logic [PKG_DATA_WIDTH-1:0]     imm;
        logic [PKG_DATA_WIDTH-1:0]     pc;
    } id_ex_t;

    // A flushed slot: nothing valid, nothing written, a harmless ADD of zeros.
    function automatic id_ex_t id_ex_bubble();
        id_ex_t b;
        b        = '0;
        b.alu_op = ALU_ADD;
        return b;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select for one source register.
// Build option: ALU_OPERAND_FWD_EN enables EX/MEM and MEM/WB forwarding;
// when undefined the registered register-file value passes straight through.
module fwd_mux #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs,
    input  logic [DATA_WIDTH-1:0]     rs_data,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic                      exmem_reg_write,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic                      memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     fwd_data
);

`ifdef ALU_OPERAND_FWD_EN
    logic exmem_hit;
    logic memwb_hit;

    // Register x0 is hardwired, so a match on index 0 is never a real hazard.
    assign exmem_hit = exmem_reg_write && (rs != '0) && (exmem_rd == rs);
    assign memwb_hit = memwb_reg_write && (rs != '0) && (memwb_rd == rs);

    // The younger EX/MEM result takes priority over MEM/WB.
    always_comb begin
        fwd_data = rs_data;
        if (exmem_hit) begin
            fwd_data = exmem_result;
        end else if (memwb_hit) begin
            fwd_data = memwb_result;
        end
    end
`else
    logic unused_fwd;

    assign unused_fwd = ^{rs, exmem_rd, exmem_reg_write, exmem_result,
                          memwb_rd, memwb_reg_write, memwb_result};

    // No forwarding: the operand is the value read in decode.
    always_comb begin
        fwd_data = rs_data;
    end
`endif

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register and ALU operand selection.
// Registers the decoded instruction (hold on stall, bubble on flush), resolves
// rs1/rs2 through forwarding and selects PC/immediate sources for the ALU.
// Build option: ALU_OPERAND_FWD_EN enables operand forwarding (see fwd_mux).
//
// Handshake: there is no valid/ready pair here. in_valid qualifies the decode
// slot; stall=1 holds the stage, flush=1 loads a bubble and beats stall, and
// reset beats both.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = PKG_DATA_WIDTH,
    parameter int OPCODE_LENGTH  = PKG_OPCODE_LENGTH,
    parameter int REG_ADDR_WIDTH = PKG_REG_ADDR_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [DATA_WIDTH-1:0]     in_rs1_data,
    input  logic [DATA_WIDTH-1:0]     in_rs2_data,
    input  logic [DATA_WIDTH-1:0]     in_imm,
    input  logic [DATA_WIDTH-1:0]     in_pc,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic                      in_a_sel_pc,
    input  logic                      in_b_sel_imm,
    input  logic [OPCODE_LENGTH-1:0]  in_alu_op,
    input  logic                      in_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
    input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
    input  logic                      exmem_reg_write,
    input  logic                      memwb_reg_write,
    input  logic [DATA_WIDTH-1:0]     exmem_result,
    input  logic [DATA_WIDTH-1:0]     memwb_result,
    output logic [DATA_WIDTH-1:0]     SrcA,
    output logic [DATA_WIDTH-1:0]     SrcB,
    output logic [OPCODE_LENGTH-1:0]  Operation,
    output logic                      ex_valid,
    output logic [REG_ADDR_WIDTH-1:0] ex_rd,
    output logic                      ex_reg_write,
    output logic [DATA_WIDTH-1:0]     ex_store_data,
    output logic [DATA_WIDTH-1:0]     ex_pc
);

    id_ex_t                  id_ex_q;
    id_ex_t                  id_ex_d;
    logic [DATA_WIDTH-1:0]   fa;
    logic [DATA_WIDTH-1:0]   fb;

    // Next ID/EX contents: flush wins, otherwise load unless stalled.
    always_comb begin
        id_ex_d = id_ex_q;
        if (flush) begin
            id_ex_d = id_ex_bubble();
        end else if (!stall) begin
            id_ex_d.valid     = in_valid;
            id_ex_d.reg_write = in_reg_write;
            id_ex_d.a_sel_pc  = in_a_sel_pc;
            id_ex_d.b_sel_imm = in_b_sel_imm;
            id_ex_d.alu_op    = in_alu_op;
            id_ex_d.rs1       = in_rs1;
            id_ex_d.rs2       = in_rs2;
            id_ex_d.rd        = in_rd;
            id_ex_d.rs1_data  = in_rs1_data;
            id_ex_d.rs2_data  = in_rs2_data;
            id_ex_d.imm       = in_imm;
            id_ex_d.pc        = in_pc;
        end
    end

    // ID/EX register; reset clears everything, including the opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_ex_q <= '0;
        end else begin
            id_ex_q <= id_ex_d;
        end
    end

    // Forwarding is combinational on the registered indices, so a stalled
    // instruction keeps picking up newly arriving downstream results.
    fwd_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs1 (
        .rs              (id_ex_q.rs1),
        .rs_data         (id_ex_q.rs1_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fa)
    );

    fwd_mux #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_fwd_rs2 (
        .rs              (id_ex_q.rs2),
        .rs_data         (id_ex_q.rs2_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .fwd_data        (fb)
    );

    // ALU operand muxes; the store value is always the forwarded rs2.
    always_comb begin
        SrcA          = id_ex_q.a_sel_pc  ? id_ex_q.pc  : fa;
        SrcB          = id_ex_q.b_sel_imm ? id_ex_q.imm : fb;
        ex_store_data = fb;
    end

    assign Operation    = id_ex_q.alu_op;
    assign ex_valid     = id_ex_q.valid;
    assign ex_rd        = id_ex_q.rd;
    assign ex_reg_write = id_ex_q.valid & id_ex_q.reg_write;
    assign ex_pc        = id_ex_q.pc;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage. Expected output sets are pushed when
// an instruction is driven and popped/compared one clock later.
// Expectations follow the ALU_OPERAND_FWD_EN build option.
module tb_alu_operand_stage;

`ifdef ALU_OPERAND_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {valid, reg_write, rd, op, SrcA, SrcB, store_data, pc}
    localparam int EXP_W = 1 + 1 + 5 + 4 + 32 * 4;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic        in_a_sel_pc;
    logic        in_b_sel_imm;
    logic [3:0]  in_alu_op;
    logic        in_reg_write;
    logic [4:0]  exmem_rd;
    logic [4:0]  memwb_rd;
    logic        exmem_reg_write;
    logic        memwb_reg_write;
    logic [31:0] exmem_result;
    logic [31:0] memwb_result;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [3:0]  Operation;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic [31:0] ex_store_data;
    logic [31:0] ex_pc;

    logic [EXP_W-1:0] exp_q[$];
    int compared;
    int mismatched;

    alu_operand_stage dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_rs1_data     (in_rs1_data),
        .in_rs2_data     (in_rs2_data),
        .in_imm          (in_imm),
        .in_pc           (in_pc),
        .in_rs1          (in_rs1),
        .in_rs2          (in_rs2),
        .in_rd           (in_rd),
        .in_a_sel_pc     (in_a_sel_pc),
        .in_b_sel_imm    (in_b_sel_imm),
        .in_alu_op       (in_alu_op),
        .in_reg_write    (in_reg_write),
        .exmem_rd        (exmem_rd),
        .memwb_rd        (memwb_rd),
        .exmem_reg_write (exmem_reg_write),
        .memwb_reg_write (memwb_reg_write),
        .exmem_result    (exmem_result),
        .memwb_result    (memwb_result),
        .SrcA            (SrcA),
        .SrcB            (SrcB),
        .Operation       (Operation),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_store_data   (ex_store_data),
        .ex_pc           (ex_pc)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [31:0] pc, input logic asel,
                         input logic bsel, input logic [3:0] op, input logic rw);
        in_valid     = v;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_rd        = rd;
        in_rs1_data  = d1;
        in_rs2_data  = d2;
        in_imm       = imm;
        in_pc        = pc;
        in_a_sel_pc  = asel;
        in_b_sel_imm = bsel;
        in_alu_op    = op;
        in_reg_write = rw;
    endtask

    task automatic set_fwd(input logic [4:0] erd, input logic ewe, input logic [31:0] eres,
                           input logic [4:0] mrd, input logic mwe, input logic [31:0] mres);
        exmem_rd        = erd;
        exmem_reg_write = ewe;
        exmem_result    = eres;
        memwb_rd        = mrd;
        memwb_reg_write = mwe;
        memwb_result    = mres;
    endtask

    task automatic expect_out(input logic v, input logic rw, input logic [4:0] rd,
                              input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] st, input logic [31:0] pc);
        exp_q.push_back({v, rw, rd, op, a, b, st, pc});
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check(input string tag);
        logic [EXP_W-1:0] e;
        compared++;
        assert (exp_q.size() != 0) else begin
            mismatched++;
            $error("FAIL %s: observed empty scoreboard expected one entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp({tag, ".ex_valid"},      32'(ex_valid),     32'(e[138]));
            cmp({tag, ".ex_reg_write"},  32'(ex_reg_write), 32'(e[137]));
            cmp({tag, ".ex_rd"},         32'(ex_rd),        32'(e[136:132]));
            cmp({tag, ".Operation"},     32'(Operation),    32'(e[131:128]));
            cmp({tag, ".SrcA"},          SrcA,              e[127:96]);
            cmp({tag, ".SrcB"},          SrcB,              e[95:64]);
            cmp({tag, ".ex_store_data"}, ex_store_data,     e[63:32]);
            cmp({tag, ".ex_pc"},         ex_pc,             e[31:0]);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        stall      = 1'b0;
        flush      = 1'b0;
        set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);

        // Reset while a valid instruction is presented
        reset = 1'b1;
        drive(1'b1, 5'd1, 5'd2, 5'd7, 32'h11, 32'h22, 32'h33, 32'h44, 1'b0, 1'b0, 4'b0100, 1'b1);
        expect_out(1'b0, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        tick();
        check("reset");

        // First edge after reset with in_valid=0 is a bubble
        reset = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b0);
        expect_out(1'b0, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("post_reset");

        // AUIPC-style: SrcA=PC, SrcB=imm, visible exactly one edge later
        drive(1'b1, 5'd1, 5'd2, 5'd5, 32'hAAAA, 32'hBBBB, 32'h2000, 32'h1000, 1'b1, 1'b1, 4'b0100, 1'b1);
        expect_out(1'b1, 1'b1, 5'd5, 4'b0100, 32'h1000, 32'h2000, 32'hBBBB, 32'h1000);
        cmp("auipc.pre_edge.SrcA", SrcA, 32'h0);
        tick();
        check("auipc");

        // Double match on rs1: EX/MEM wins
        set_fwd(5'd3, 1'b1, 32'h77, 5'd3, 1'b1, 32'h99);
        drive(1'b1, 5'd3, 5'd4, 5'd6, 32'h5, 32'h44, 32'h0, 32'h1004, 1'b0, 1'b0, 4'b0010, 1'b1);
        expect_out(1'b1, 1'b1, 5'd6, 4'b0010, FWD ? 32'h77 : 32'h5, 32'h44, 32'h44, 32'h1004);
        tick();
        check("fwd_exmem_prio");

        // MEM/WB only, both sources
        set_fwd(5'd3, 1'b0, 32'h77, 5'd3, 1'b1, 32'h99);
        drive(1'b1, 5'd3, 5'd3, 5'd7, 32'h5, 32'h6, 32'h0, 32'h1008, 1'b0, 1'b0, 4'b0001, 1'b1);
        expect_out(1'b1, 1'b1, 5'd7, 4'b0001, FWD ? 32'h99 : 32'h5,
                   FWD ? 32'h99 : 32'h6, FWD ? 32'h99 : 32'h6, 32'h1008);
        tick();
        check("fwd_memwb");

        // Index 0 never forwarded
        set_fwd(5'd0, 1'b1, 32'hEE, 5'd0, 1'b1, 32'hFF);
        drive(1'b1, 5'd0, 5'd0, 5'd8, 32'h12, 32'h0, 32'h0, 32'h100C, 1'b0, 1'b0, 4'b0011, 1'b1);
        expect_out(1'b1, 1'b1, 5'd8, 4'b0011, 32'h12, 32'h0, 32'h0, 32'h100C);
        tick();
        check("x0_no_fwd");

        // Immediate SrcB while the store data still gets forwarded rs2
        set_fwd(5'd9, 1'b1, 32'h55, 5'd0, 1'b0, 32'h0);
        drive(1'b1, 5'd0, 5'd9, 5'd10, 32'h0, 32'h1, 32'h10, 32'h1010, 1'b0, 1'b1, 4'b0100, 1'b0);
        expect_out(1'b1, 1'b0, 5'd10, 4'b0100, 32'h0, 32'h10, FWD ? 32'h55 : 32'h1, 32'h1010);
        tick();
        check("imm_store_fwd");

        // Load an instruction, then stall it with new decode inputs
        set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        drive(1'b1, 5'd2, 5'd0, 5'd11, 32'h200, 32'h300, 32'h0, 32'h2000, 1'b0, 1'b0, 4'b1110, 1'b1);
        expect_out(1'b1, 1'b1, 5'd11, 4'b1110, 32'h200, 32'h300, 32'h300, 32'h2000);
        tick();
        check("pre_stall");

        stall = 1'b1;
        drive(1'b0, 5'd0, 5'd1, 5'd1, 32'hDEAD, 32'hBEEF, 32'h7, 32'h3000, 1'b1, 1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 2; i++) begin
            expect_out(1'b1, 1'b1, 5'd11, 4'b1110, 32'h200, 32'h300, 32'h300, 32'h2000);
            tick();
            check("stall_hold");
        end

        // Result arriving during the stall is picked up by the held rs1
        set_fwd(5'd2, 1'b1, 32'h5151, 5'd0, 1'b0, 32'h0);
        expect_out(1'b1, 1'b1, 5'd11, 4'b1110, FWD ? 32'h5151 : 32'h200, 32'h300, 32'h300, 32'h2000);
        tick();
        check("stall_fwd");

        // Flush beats stall
        set_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
        flush = 1'b1;
        expect_out(1'b0, 1'b0, 5'd0, 4'b0100, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("flush_over_stall");

        // Resume with a LUI
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b1, 5'd0, 5'd0, 5'd12, 32'h0, 32'h7, 32'hABCDE000, 32'h2004, 1'b0, 1'b1, 4'b1010, 1'b1);
        expect_out(1'b1, 1'b1, 5'd12, 4'b1010, 32'h0, 32'hABCDE000, 32'h7, 32'h2004);
        tick();
        check("resume_lui");

        // Reset beats flush and stall: opcode clears to 0000, not ADD
        reset = 1'b1;
        flush = 1'b1;
        stall = 1'b1;
        expect_out(1'b0, 1'b0, 5'd0, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0);
        tick();
        check("reset_over_flush");

        reset = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
